// File: rtl/id_regfile_pkg.sv
// Shared widths and constants for the ID-stage register file and its
// write-pending scoreboard.
package id_regfile_pkg;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NREG     = 32;
    localparam int          CNT_W    = 2;
    localparam int          CNT_MAX  = 3;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/id_regfile_sb_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// The err output is sticky until reset.
module sb_counter
    import id_regfile_pkg::*;
#(
    parameter int CNT_W = id_regfile_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Simultaneous inc and dec cancel, so they never trip either limit.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_q == MAX) err_d = 1'b1;
                else              cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | err_d;
        end
    end

    assign cnt = cnt_q;
    assign err = err_q;

endmodule

// File: rtl/id_regfile.sv
// ID-stage register file with WB bypass and a per-register write-pending
// scoreboard that stalls instructions whose sources are still in flight.
module id_regfile
    import id_regfile_pkg::*;
#(
    parameter int DATA_W = id_regfile_pkg::DATA_W,
    parameter int NREG   = id_regfile_pkg::NREG,
    parameter int CNT_W  = id_regfile_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    input  logic              id_issue,
    input  logic [ADDR_W-1:0] id_issue_destR,
    output logic              id_stall,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_destR,
    input  logic [DATA_W-1:0] wb_dest,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   inc, dec, pend, cnt_err;
    logic              ret, iss;

    assign ret = wb_wreg && (wb_destR != REG_ZERO);
    assign iss = id_issue && !id_stall && (id_issue_destR != REG_ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (ret) begin
            regs_q[wb_destR] <= wb_dest;
        end
    end

    assign id_rs_data = (id_rs_addr == REG_ZERO) ? '0 :
                        (ret && (wb_destR == id_rs_addr)) ? wb_dest : regs_q[id_rs_addr];
    assign id_rt_data = (id_rt_addr == REG_ZERO) ? '0 :
                        (ret && (wb_destR == id_rt_addr)) ? wb_dest : regs_q[id_rt_addr];
    assign dbg_data   = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];

    assign inc[0]     = 1'b0;
    assign dec[0]     = 1'b0;
    assign pend[0]    = 1'b0;
    assign cnt_err[0] = 1'b0;

    // pend uses the count as it will be after this cycle's retire, so a
    // dependent instruction leaves ID in the same cycle its producer retires.
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        assign inc[r] = iss && (id_issue_destR == ADDR_W'(r));
        assign dec[r] = ret && (wb_destR == ADDR_W'(r));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[r]),
            .dec (dec[r]),
            .cnt (cnt),
            .err (cnt_err[r])
        );

        assign pend[r] = (cnt > CNT_W'(1)) || ((cnt == CNT_W'(1)) && !dec[r]);
    end

    assign id_stall = (id_rs_use && pend[id_rs_addr]) || (id_rt_use && pend[id_rt_addr]);
    assign sb_err   = |cnt_err;

endmodule

// File: tb/tb_id_regfile.sv
// Directed bench for id_regfile: reset, bypass, r0 handling, scoreboard
// stall/issue/retire interplay, saturation errors and async reset.
module tb_id_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0;
    logic        id_rs_use = 1'b0, id_rt_use = 1'b0;
    logic [31:0] id_rs_data, id_rt_data;
    logic        id_issue = 1'b0;
    logic [4:0]  id_issue_destR = '0;
    logic        id_stall;
    logic        wb_wreg = 1'b0;
    logic [4:0]  wb_destR = '0;
    logic [31:0] wb_dest = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_use      (id_rs_use),
        .id_rt_use      (id_rt_use),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_issue       (id_issue),
        .id_issue_destR (id_issue_destR),
        .id_stall       (id_stall),
        .wb_wreg        (wb_wreg),
        .wb_destR       (wb_destR),
        .wb_dest        (wb_dest),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .sb_err         (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_issue = 1'b0;
        wb_wreg  = 1'b0;
    endtask

    initial begin
        // Reset held low: combinational outputs quiet
        #2;
        chk("rst_stall", {31'b0, id_stall}, 32'd0);
        chk("rst_sberr", {31'b0, sb_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("rst_dbg_r%0d", a), dbg_data, 32'd0);
        end
        chk("rst_rs_data", id_rs_data, 32'd0);

        // Issue r5, three idle cycles stalled, retire with bypass
        id_rs_addr = 5'd5; id_rs_use = 1'b1; id_rt_addr = 5'd5;
        #1 chk("r5_pre_stall", {31'b0, id_stall}, 32'd0);
        id_issue = 1'b1; id_issue_destR = 5'd5;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("r5_stall_c%0d", c), {31'b0, id_stall}, 32'd1);
            tick();
        end
        wb_wreg = 1'b1; wb_destR = 5'd5; wb_dest = 32'hDEADBEEF;
        #1;
        chk("r5_ret_stall", {31'b0, id_stall}, 32'd0);
        chk("r5_ret_rs", id_rs_data, 32'hDEADBEEF);
        chk("r5_ret_rt", id_rt_data, 32'hDEADBEEF);
        chk("r5_ret_dbg_old", dbg_data, 32'd0);
        tick();
        idle();
        dbg_addr = 5'd5;
        #1;
        chk("r5_dbg", dbg_data, 32'hDEADBEEF);
        chk("r5_post_stall", {31'b0, id_stall}, 32'd0);
        chk("r5_sberr", {31'b0, sb_err}, 32'd0);

        // r0: write dropped, issue ignored, no retire underflow
        wb_wreg = 1'b1; wb_destR = 5'd0; wb_dest = 32'h1234;
        id_issue = 1'b1; id_issue_destR = 5'd0;
        id_rs_addr = 5'd0;
        #1;
        chk("r0_rs_bypass", id_rs_data, 32'd0);
        chk("r0_stall", {31'b0, id_stall}, 32'd0);
        tick();
        idle();
        dbg_addr = 5'd0;
        #1;
        chk("r0_dbg", dbg_data, 32'd0);
        chk("r0_stall_after", {31'b0, id_stall}, 32'd0);
        chk("r0_sberr", {31'b0, sb_err}, 32'd0);

        // r7: cnt 1, then simultaneous issue+retire keeps it at 1
        id_rs_use = 1'b0;
        id_issue = 1'b1; id_issue_destR = 5'd7;
        tick();
        wb_wreg = 1'b1; wb_destR = 5'd7; wb_dest = 32'h77;
        tick();
        idle();
        id_rs_addr = 5'd7; id_rs_use = 1'b1;
        #1 chk("r7_stall_cnt1", {31'b0, id_stall}, 32'd1);
        wb_wreg = 1'b1; wb_destR = 5'd7; wb_dest = 32'h78;
        #1 chk("r7_ret_stall", {31'b0, id_stall}, 32'd0);
        chk("r7_ret_rs", id_rs_data, 32'h78);
        tick();
        idle();
        #1;
        chk("r7_drained", {31'b0, id_stall}, 32'd0);
        chk("r7_sberr", {31'b0, sb_err}, 32'd0);

        // r9: three issues, fourth overflows and saturates at 3
        id_rs_use = 1'b0;
        id_issue = 1'b1; id_issue_destR = 5'd9;
        tick(); tick(); tick();
        id_issue = 1'b0;
        id_rs_addr = 5'd9; id_rs_use = 1'b1;
        #1;
        chk("r9_stall3", {31'b0, id_stall}, 32'd1);
        chk("r9_sberr3", {31'b0, sb_err}, 32'd0);
        id_rs_use = 1'b0;
        id_issue = 1'b1;
        tick();
        idle();
        chk("r9_overflow", {31'b0, sb_err}, 32'd1);
        id_rs_use = 1'b1;
        wb_wreg = 1'b1; wb_destR = 5'd9; wb_dest = 32'h99;
        tick();
        tick();
        idle();
        #1 chk("r9_after2ret", {31'b0, id_stall}, 32'd1);
        wb_wreg = 1'b1;
        #1 chk("r9_ret3_stall", {31'b0, id_stall}, 32'd0);
        tick();
        idle();
        #1;
        chk("r9_drained", {31'b0, id_stall}, 32'd0);
        chk("r9_sberr_sticky", {31'b0, sb_err}, 32'd1);

        // Fresh reset, then retire to r3 with nothing pending
        rst = 1'b0;
        #1;
        chk("rst2_sberr", {31'b0, sb_err}, 32'd0);
        dbg_addr = 5'd5;
        #1 chk("rst2_r5_cleared", dbg_data, 32'd0);
        tick();
        rst = 1'b1;
        id_rs_use = 1'b0;
        wb_wreg = 1'b1; wb_destR = 5'd3; wb_dest = 32'h3333;
        tick();
        idle();
        dbg_addr = 5'd3;
        #1;
        chk("r3_underflow", {31'b0, sb_err}, 32'd1);
        chk("r3_written", dbg_data, 32'h3333);

        // Issue while stalled is dropped; async reset drops stall at once
        rst = 1'b0;
        tick();
        rst = 1'b1;
        id_issue = 1'b1; id_issue_destR = 5'd4;
        tick();
        id_rs_addr = 5'd4; id_rs_use = 1'b1;
        id_issue_destR = 5'd6;
        #1 chk("stall_r4", {31'b0, id_stall}, 32'd1);
        tick();
        idle();
        id_rs_addr = 5'd6;
        #1 chk("r6_not_issued", {31'b0, id_stall}, 32'd0);
        id_rs_use = 1'b0;
        id_rt_addr = 5'd4; id_rt_use = 1'b1;
        #1 chk("rt_stall_r4", {31'b0, id_stall}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_stall", {31'b0, id_stall}, 32'd0);
        chk("async_rst_sberr", {31'b0, sb_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_stall", {31'b0, id_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
